seq_mult_param: RTL and testbench
=================================

Name: seq_mult_param

Overview:
Parametrised sequential shift-add multiplier. It is the successor to the team's fixed 4-bit shift-add multiplier and adds four things: a configurable operand width, a start/busy/done handshake, a run-time signed/unsigned mode, and a fixed, documented latency. It sits between operand registers (switch or datapath inputs) and the result display/consumer logic. It computes one product per request.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32; product width is 2*WIDTH.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- signed_mode  input  1  0 = unsigned operands, 1 = two's-complement operands; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- p  output  2*WIDTH  registered product; holds its value until the next done.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse, asserted in the same cycle p is first valid.

Behaviour:
- Reset: one clock, synchronous, active-high (clk, rst). While rst is high at a clk edge: state becomes IDLE, p=0, busy=0, done=0, and all internal registers are cleared. rst has priority over every other input. Asserting rst mid-operation aborts it: no done is produced and p stays 0.
- States:
  - IDLE: busy=0. If start=1 at edge E0, latch the operands and go to MULT.
    - In unsigned mode, latch a and b as they are.
    - In signed mode, latch |a| and |b| (magnitude, WIDTH bits unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1)) and neg = a[MSB]^b[MSB].
    - Clear the accumulator (2*WIDTH bits) and the iteration counter (clog2(WIDTH+1) bits).
  - MULT: busy=1. On each edge:
    - If the multiplier LSB is 1, acc += multiplicand (the multiplicand is zero-extended to 2*WIDTH bits).
    - Then shift the multiplicand left 1, shift the multiplier right 1, and increment the counter.
    - Exactly WIDTH iterations are performed, on edges E1..EWIDTH. There is no early exit on a zero multiplier, so latency is constant.
    - After the WIDTH-th iteration, go to DONE.
  - DONE: on edge E(WIDTH+1), p <= (neg ? -acc : acc) truncated to 2*WIDTH bits, done <= 1, busy <= 0, and the state returns to IDLE.
- done is high for exactly one cycle. It deasserts on the next edge unless a new operation completes on that edge, which is impossible because the minimum latency is greater than 1.
- Latency: start sampled at E0 gives done=1 and a valid p after E(WIDTH+1). That is WIDTH+1 cycles, and back-to-back throughput is one product per WIDTH+2 cycles.
- busy rises after E0 and falls at E(WIDTH+1), the same edge on which done rises.
- start while busy=1 is ignored. It is not queued, and the operands and signed_mode are not re-sampled.
- start in the cycle done=1 is accepted, because the state is already IDLE.
- Changes to a, b or signed_mode after E0 have no effect on the operation in flight.
- Arithmetic: the unsigned result is exact in 2*WIDTH bits. The signed result is exact in 2*WIDTH-bit two's complement, including (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2).
- Zero operand in either mode: the full latency still applies and p=0 (no negative zero, since -0 = 0).
- The design contains no combinational loops and no latches. Every output is driven from a register.

Test Plan:
- WIDTH=4, unsigned, a=15, b=15, start for one cycle -> busy high for 5 cycles; done pulses once, 5 cycles after the start edge, with p=8'hE1 (225); p holds 8'hE1 afterwards.
- WIDTH=4, signed:
  - a=4'hD (-3), b=5 -> p=8'hF1 (-15).
  - Then a=4'h8, b=4'h8 -> p=8'h40 (64).
  - Then a=4'h8, b=7 -> p=8'hC8 (-56).
- WIDTH=4: start with a=6, b=7, then pulse start again at cycle 2 with a=1, b=1 -> the second start is ignored; exactly one done, p=8'h2A. Next, assert start in the done cycle with a=2, b=3 -> accepted; the next done gives p=8'h06.
- WIDTH=4: start with a=9, b=9, then assert rst at cycle 3 -> on the following edge busy=0, done=0, p=0; no done ever appears for the aborted operation. A new start with a=3, b=3 then gives p=9 after 5 cycles.
- WIDTH=4: a=0, b=13, unsigned -> done still occurs after 5 cycles with p=0. Signed a=0, b=4'hF -> p=0.
- WIDTH=8 instance: unsigned a=255, b=255 -> done after 9 cycles with p=16'hFE01. Signed a=8'h80, b=8'hFF -> p=16'h0080 (128).

Source files
------------

// File: rtl/seq_mult_param.sv
// Parametrised sequential shift-add multiplier with start/busy/done handshake,
// run-time signed/unsigned mode and a constant latency of WIDTH+1 cycles.
module seq_mult_param #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p,
    output logic               busy,
    output logic               done
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MULT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PW_ONE    = {{(PW-1){1'b0}}, 1'b1};

    // The most negative operand maps onto 2^(WIDTH-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            magnitude = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            magnitude = v;
        end
    endfunction

    logic [1:0]       state_q,  state_d;
    logic [PW-1:0]    mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q,    acc_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             neg_q,    neg_d;
    logic [PW-1:0]    p_q,      p_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    // Next-state and datapath logic for the IDLE -> MULT -> DONE sequence.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        p_d      = p_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (signed_mode) begin
                        mcand_d  = {{WIDTH{1'b0}}, magnitude(a)};
                        mplier_d = magnitude(b);
                        neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
                    end else begin
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        neg_d    = 1'b0;
                    end
                    acc_d   = {PW{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
                    state_d = MULT;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            MULT: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_ONE;
                // No early exit on a zero multiplier: latency stays constant.
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                end else begin
                    state_d = MULT;
                end
            end
            DONE: begin
                if (neg_q) begin
                    p_d = ~acc_q + PW_ONE;
                end else begin
                    p_d = acc_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= {PW{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {PW{1'b0}};
            cnt_q    <= {CW{1'b0}};
            neg_q    <= 1'b0;
            p_q      <= {PW{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            p_q      <= p_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign p    = p_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param: WIDTH=4 and WIDTH=8 instances,
// directed cases plus randomized operations against an arithmetic reference.
module tb_seq_mult_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start4 = 1'b0, sm4 = 1'b0;
    logic [3:0]  a4 = 4'd0, b4 = 4'd0;
    logic [7:0]  p4;
    logic        busy4, done4;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = 8'd0, b8 = 8'd0;
    logic [15:0] p8;
    logic        busy8, done8;

    int checks = 0;
    int errors = 0;
    int done_cnt4 = 0;

    seq_mult_param #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
        .a(a4), .b(b4), .p(p4), .busy(busy4), .done(done4)
    );

    seq_mult_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .p(p8), .busy(busy8), .done(done8)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done4) done_cnt4 <= done_cnt4 + 1;
    end

    // Reference: interpret operands per mode, multiply, keep 2*w low bits.
    function automatic longint ref_mult(input int w, input longint a, input longint b, input bit sm);
        longint full;
        full = longint'(1) << w;
        if (sm) begin
            if (a >= full / 2) a = a - full;
            if (b >= full / 2) b = b - full;
        end
        return (a * b) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // Start is presented for one edge (E0); inputs are scrambled right after.
    task automatic launch4(input logic [3:0] a, input logic [3:0] b, input logic sm);
        @(negedge clk);
        a4 = a; b4 = b; sm4 = sm; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        a4 = 4'($urandom_range(0, 15));
        b4 = 4'($urandom_range(0, 15));
        sm4 = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done4(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = busy4 ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done4) break;
            if (busy4) busy_cnt++;
        end
    endtask

    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic sm);
        @(negedge clk);
        a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(0, 255));
        sm8 = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done8) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({p4, busy4, done4} !== 10'd0) begin
            errors++; $display("FAIL reset4 got p=%h busy=%b done=%b want 0/0/0", p4, busy4, done4);
        end
        checks++;
        if ({p8, busy8, done8} !== 18'd0) begin
            errors++; $display("FAIL reset8 got p=%h busy=%b done=%b want 0/0/0", p8, busy8, done8);
        end
        rst = 1'b0;
    endtask

    task automatic test_unsigned_max();
        int lat, bc;
        launch4(4'd15, 4'd15, 1'b0);
        wait_done4(lat, bc);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL umax_latency got %0d want 5", lat); end
        checks++;
        if (bc !== 5) begin errors++; $display("FAIL umax_busy_cycles got %0d want 5", bc); end
        checks++;
        if (p4 !== 8'hE1) begin errors++; $display("FAIL umax_p got %h want e1", p4); end
        checks++;
        if (busy4 !== 1'b0) begin errors++; $display("FAIL umax_busy_at_done got %b want 0", busy4); end
        @(posedge clk); #1;
        checks++;
        if (done4 !== 1'b0) begin errors++; $display("FAIL umax_done_pulse got %b want 0", done4); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (p4 !== 8'hE1) begin errors++; $display("FAIL umax_p_hold got %h want e1", p4); end
    endtask

    task automatic test_signed();
        int lat, bc;
        logic [3:0] av [3] = '{4'hD, 4'h8, 4'h8};
        logic [3:0] bv [3] = '{4'h5, 4'h8, 4'h7};
        logic [7:0] pv [3] = '{8'hF1, 8'h40, 8'hC8};
        for (int i = 0; i < 3; i++) begin
            launch4(av[i], bv[i], 1'b1);
            wait_done4(lat, bc);
            checks++;
            if (p4 !== pv[i] || lat !== 5) begin
                errors++; $display("FAIL signed_%0d got p=%h lat=%0d want p=%h lat=5", i, p4, lat, pv[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc, d0;
        d0 = done_cnt4;
        launch4(4'd6, 4'd7, 1'b0);
        @(posedge clk); #1;
        a4 = 4'd1; b4 = 4'd1; sm4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        wait_done4(lat, bc);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL b2b_first_latency got %0d want 3", lat); end
        checks++;
        if (p4 !== 8'h2A) begin errors++; $display("FAIL b2b_first_p got %h want 2a", p4); end
        a4 = 4'd2; b4 = 4'd3; sm4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        checks++;
        if (busy4 !== 1'b1) begin errors++; $display("FAIL b2b_accept_in_done got busy=%b want 1", busy4); end
        wait_done4(lat, bc);
        checks++;
        if (p4 !== 8'h06 || lat !== 5) begin
            errors++; $display("FAIL b2b_second got p=%h lat=%0d want p=06 lat=5", p4, lat);
        end
        @(negedge clk);
        checks++;
        if (done_cnt4 - d0 !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_cnt4 - d0); end
    endtask

    task automatic test_abort();
        int lat, bc, d0;
        launch4(4'd9, 4'd9, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({p4, busy4, done4} !== 10'd0) begin
            errors++; $display("FAIL abort_clear got p=%h busy=%b done=%b want 0/0/0", p4, busy4, done4);
        end
        rst = 1'b0;
        d0 = done_cnt4;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (done_cnt4 !== d0 || p4 !== 8'h00) begin
            errors++; $display("FAIL abort_no_done got dones=%0d p=%h want 0 dones p=00", done_cnt4 - d0, p4);
        end
        launch4(4'd3, 4'd3, 1'b0);
        wait_done4(lat, bc);
        checks++;
        if (p4 !== 8'h09 || lat !== 5) begin
            errors++; $display("FAIL abort_restart got p=%h lat=%0d want p=09 lat=5", p4, lat);
        end
    endtask

    task automatic test_zero();
        int lat, bc;
        launch4(4'd0, 4'd13, 1'b0);
        wait_done4(lat, bc);
        checks++;
        if (p4 !== 8'h00 || lat !== 5) begin
            errors++; $display("FAIL zero_unsigned got p=%h lat=%0d want p=00 lat=5", p4, lat);
        end
        launch4(4'd0, 4'hF, 1'b1);
        wait_done4(lat, bc);
        checks++;
        if (p4 !== 8'h00 || lat !== 5) begin
            errors++; $display("FAIL zero_signed got p=%h lat=%0d want p=00 lat=5", p4, lat);
        end
    endtask

    task automatic test_random4();
        int lat, bc;
        logic [3:0] a, b;
        logic sm;
        logic [7:0] exp;
        for (int i = 0; i < 30; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            sm = 1'($urandom_range(0, 1));
            exp = 8'(ref_mult(4, longint'(a), longint'(b), sm));
            launch4(a, b, sm);
            wait_done4(lat, bc);
            checks++;
            if (p4 !== exp || lat !== 5) begin
                errors++;
                $display("FAIL rand4 a=%h b=%h sm=%b got p=%h lat=%0d want p=%h lat=5", a, b, sm, p4, lat, exp);
            end
        end
    endtask

    task automatic test_width8();
        int lat;
        logic [7:0] a, b;
        logic sm;
        logic [15:0] exp;
        launch8(8'hFF, 8'hFF, 1'b0);
        wait_done8(lat);
        checks++;
        if (p8 !== 16'hFE01 || lat !== 9) begin
            errors++; $display("FAIL w8_umax got p=%h lat=%0d want p=fe01 lat=9", p8, lat);
        end
        launch8(8'h80, 8'hFF, 1'b1);
        wait_done8(lat);
        checks++;
        if (p8 !== 16'h0080 || lat !== 9) begin
            errors++; $display("FAIL w8_smin got p=%h lat=%0d want p=0080 lat=9", p8, lat);
        end
        for (int i = 0; i < 15; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            sm = 1'($urandom_range(0, 1));
            exp = 16'(ref_mult(8, longint'(a), longint'(b), sm));
            launch8(a, b, sm);
            wait_done8(lat);
            checks++;
            if (p8 !== exp || lat !== 9) begin
                errors++;
                $display("FAIL rand8 a=%h b=%h sm=%b got p=%h lat=%0d want p=%h lat=9", a, b, sm, p8, lat, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed();
        test_back_to_back();
        test_abort();
        test_zero();
        test_random4();
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
